// File: rtl/ft245_bus_arbiter.sv
// ft245_bus_arbiter: FT2232H 245-synchronous FIFO bus sequencer/arbiter between TX and RX user streams.
// Define FT_SEND_IM_EN to enable FLUSH-driven SEND_IM (SI/WUA#) pulses.
module ft245_bus_arbiter #(
  parameter int TX_BURST_MAX = 64,
  parameter int RX_BURST_MAX = 64
) (
  input  logic       CLK_FTDI,
  input  logic       RST,
  input  logic       TX_FULL,
  input  logic       RX_EMPTY,
  input  logic [7:0] DATA_IN,
  output logic [7:0] DATA_OUT,
  output logic       DATA_OE,
  output logic       READ_N,
  output logic       WRITE_N,
  output logic       OUT_EN,
  output logic       SEND_IM,
  input  logic       TX_VALID,
  input  logic [7:0] TX_DATA,
  output logic       TX_READY,
  output logic       RX_VALID,
  output logic [7:0] RX_DATA,
  input  logic       RX_READY,
  input  logic       FLUSH
);
  localparam int BMAX = TX_BURST_MAX > RX_BURST_MAX ? TX_BURST_MAX : RX_BURST_MAX;
  localparam int BW = $clog2(BMAX + 1);
  localparam logic [BW-1:0] TX_LIM = BW'(TX_BURST_MAX);
  localparam logic [BW-1:0] RX_LIM = BW'(RX_BURST_MAX);
  localparam logic [BW-1:0] B_SAT = BW'(BMAX);

  typedef enum logic [2:0] {
    IDLE, TX, RX_TURN, RX, RX_EXIT
`ifdef FT_SEND_IM_EN
    , SI
`endif
  } state_e;

  state_e state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic last_rx_q, last_rx_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic rx_space, rx_pend, tx_pend, push, pop, xfer, grant_rx, grant_tx;

  always_comb begin
    rx_space = (cnt_q < 2'd2) || RX_READY;
    rx_pend = !RX_EMPTY && rx_space;
    tx_pend = TX_VALID && !TX_FULL;
  end

`ifdef FT_SEND_IM_EN
  logic flush_pend_q, flush_pend_d;
  always_comb flush_pend_d = FLUSH || (flush_pend_q && state_q != SI);
  always_ff @(posedge CLK_FTDI) flush_pend_q <= RST ? 1'b0 : flush_pend_d;
`else
  logic unused_flush;
  assign unused_flush = FLUSH;
`endif

  // WRITE_N/READ_N follow the FIFO flags combinationally so a flag edge never loses or repeats a byte
  always_comb begin
    DATA_OE = state_q == TX;
    WRITE_N = !(state_q == TX && tx_pend);
    TX_READY = !WRITE_N;
    OUT_EN = !(state_q == RX_TURN || state_q == RX);
    READ_N = !(state_q == RX && rx_pend);
`ifdef FT_SEND_IM_EN
    SEND_IM = state_q != SI;
`else
    SEND_IM = 1'b1;
`endif
  end

  assign DATA_OUT = TX_DATA;
  assign RX_VALID = cnt_q != 2'd0;
  assign RX_DATA = buf0_q;

  always_comb begin
    push = !READ_N;
    pop = RX_READY && cnt_q != 2'd0;
    xfer = !WRITE_N || !READ_N;
    burst_d = (state_q == TX || state_q == RX) ? burst_q + BW'(xfer && burst_q != B_SAT) : '0;
  end

  // two-entry skid buffer: pop shifts the tail forward, push lands in the first free slot
  always_comb begin
    buf0_d = pop ? buf1_q : buf0_q;
    buf1_d = buf1_q;
    cnt_d = cnt_q - {1'b0, pop};
    if (push) begin
      buf0_d = cnt_d == 2'd0 ? DATA_IN : buf0_d;
      buf1_d = cnt_d == 2'd0 ? buf1_q : DATA_IN;
      cnt_d = cnt_d + 2'd1;
    end
  end

  // burst limits count the byte moving this cycle so a grant never exceeds its maximum
  always_comb begin
    grant_rx = rx_pend && (!tx_pend || !last_rx_q);
    grant_tx = tx_pend && !grant_rx;
    state_d = state_q;
    last_rx_d = last_rx_q;
    case (state_q)
      IDLE: begin
        state_d = grant_rx ? RX_TURN : grant_tx ? TX : IDLE;
        last_rx_d = grant_rx || (last_rx_q && !grant_tx);
`ifdef FT_SEND_IM_EN
        if (flush_pend_q && !TX_VALID && !TX_FULL) begin
          state_d = SI;
          last_rx_d = last_rx_q;
        end
`endif
      end
      TX:      state_d = (!tx_pend || (rx_pend && burst_d >= TX_LIM)) ? IDLE : TX;
      RX_TURN: state_d = RX;
      RX:      state_d = (RX_EMPTY || (tx_pend && (burst_d >= RX_LIM || (cnt_q == 2'd2 && !RX_READY)))) ? RX_EXIT : RX;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_FTDI) begin
    if (RST) begin
      state_q <= IDLE;
      burst_q <= '0;
      last_rx_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_rx_q <= last_rx_d;
      cnt_q <= cnt_d;
    end
    buf0_q <= buf0_d;
    buf1_q <= buf1_d;
  end
endmodule

// File: tb/tb_ft245_bus_arbiter.sv
// tb_ft245_bus_arbiter: byte-stream scoreboard and protocol checks for ft245_bus_arbiter.
module tb_ft245_bus_arbiter;
  localparam int TXB = 4;
  localparam int RXB = 4;
  logic clk = 1'b0;
  logic rst;
  logic tx_full, rx_empty, data_oe, read_n, write_n, out_en, send_im;
  logic tx_valid, tx_ready, rx_valid, rx_ready, flush;
  logic [7:0] data_in, data_out, tx_data, rx_data;
  always #5 clk = ~clk;

  ft245_bus_arbiter #(.TX_BURST_MAX(TXB), .RX_BURST_MAX(RXB)) dut (
    .CLK_FTDI(clk), .RST(rst), .TX_FULL(tx_full), .RX_EMPTY(rx_empty), .DATA_IN(data_in),
    .DATA_OUT(data_out), .DATA_OE(data_oe), .READ_N(read_n), .WRITE_N(write_n), .OUT_EN(out_en),
    .SEND_IM(send_im), .TX_VALID(tx_valid), .TX_DATA(tx_data), .TX_READY(tx_ready),
    .RX_VALID(rx_valid), .RX_DATA(rx_data), .RX_READY(rx_ready), .FLUSH(flush)
  );

  int checks = 0, failures = 0, cyc = 0;
  logic [7:0] txq[$], tx_sent[$], host_got[$], hostq[$], rx_sent[$], skid[$], user_got[$];
  int ev[$];
  logic want_tx = 0, full_k = 0, block_k = 0, ready_k = 0, flush_k = 0;
  logic chk_en = 0, prev_oe = 1, gap_ok = 1;
  int last_dir = 0, first_wr = -1, last_wr = -1, first_rd = -1, first_oe = -1, si_cnt = 0, si_got = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive();
    tx_valid = want_tx && txq.size() != 0;
    tx_data = txq.size() != 0 ? txq[0] : 8'h00;
    rx_empty = block_k || hostq.size() == 0;
    data_in = hostq.size() != 0 ? hostq[0] : 8'h00;
    tx_full = full_k;
    rx_ready = ready_k;
    flush = flush_k;
  endtask

  task automatic monitor();
    logic wr, rd;
    wr = !write_n;
    rd = !read_n && !rx_empty;
    chk("turnaround", !out_en && data_oe, 0);
    chk("tx_ready", tx_ready, !write_n);
    chk("wr_legal", wr && !(tx_valid && !tx_full), 0);
    chk("rx_valid", rx_valid, skid.size() != 0);
    if (!read_n) chk("rd_oe", {prev_oe, out_en}, 0);
    if (!read_n) chk("rd_space", skid.size() < 2 || rx_ready, 1);
    if (wr && last_dir == 1) chk("rx_tx_gap", gap_ok, 1);
    if (rd && last_dir == 2) chk("tx_rx_gap", gap_ok, 1);
`ifdef FT_SEND_IM_EN
    if (!send_im) chk("si_quiet", {read_n, write_n, out_en, data_oe}, 4'b1110);
`else
    chk("send_im_const", send_im, 1);
`endif
    if (!send_im) begin
      si_cnt++;
      if (si_got < 0) si_got = host_got.size();
    end
    if (!out_en && first_oe < 0) first_oe = cyc;
    if (wr && txq.size() != 0) begin
      chk("wr_data", data_out, txq[0]);
      host_got.push_back(data_out);
      void'(txq.pop_front());
      ev.push_back(2);
      last_dir = 2;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
    end
    if (rx_ready && skid.size() != 0) begin
      chk("rx_data", rx_data, skid[0]);
      user_got.push_back(rx_data);
      void'(skid.pop_front());
    end
    if (rd) begin
      skid.push_back(data_in);
      void'(hostq.pop_front());
      ev.push_back(1);
      last_dir = 1;
      if (first_rd < 0) first_rd = cyc;
    end
    if (wr || rd) gap_ok = 0;
    else if (out_en && !data_oe) gap_ok = 1;
    prev_oe = out_en;
  endtask

  task automatic tick();
    drive();
    #2;
    if (chk_en) monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic add_tx(input logic [7:0] b);
    txq.push_back(b);
    tx_sent.push_back(b);
  endtask

  task automatic add_rx(input logic [7:0] b);
    hostq.push_back(b);
    rx_sent.push_back(b);
  endtask

  task automatic new_phase();
    repeat (3) tick();
    tx_sent.delete(); host_got.delete(); rx_sent.delete(); user_got.delete(); ev.delete();
    first_wr = -1; last_wr = -1; first_rd = -1; first_oe = -1; si_cnt = 0; si_got = -1;
  endtask

  task automatic check_streams(input string tag);
    int bad;
    bad = 0;
    chk({tag, "_tx_count"}, host_got.size(), tx_sent.size());
    for (int i = 0; i < host_got.size() && i < tx_sent.size(); i++) if (host_got[i] !== tx_sent[i]) bad++;
    chk({tag, "_tx_order"}, bad, 0);
    bad = 0;
    chk({tag, "_rx_count"}, user_got.size(), rx_sent.size());
    for (int i = 0; i < user_got.size() && i < rx_sent.size(); i++) if (user_got[i] !== rx_sent[i]) bad++;
    chk({tag, "_rx_order"}, bad, 0);
  endtask

  function automatic bit busy();
    return txq.size() != 0 || hostq.size() != 0 || skid.size() != 0;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n, run, prev, nruns, badrun;
    bit bp_done;
    // reset with both directions requesting
    rst = 1;
    add_tx(8'h11); add_rx(8'h22);
    want_tx = 1;
    repeat (2) tick();
    drive();
    #2;
    chk("rst_read_n", read_n, 1);
    chk("rst_write_n", write_n, 1);
    chk("rst_out_en", out_en, 1);
    chk("rst_send_im", send_im, 1);
    chk("rst_data_oe", data_oe, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    @(posedge clk); #1; cyc++;
    rst = 0; want_tx = 0;
    txq.delete(); hostq.delete();
    chk_en = 1;
    new_phase();

    // contention: RX first, then alternating bursts of TXB/RXB
    for (int i = 0; i < 40; i++) begin
      add_tx(8'(8'h40 + i)); add_rx(8'(8'hC0 + i));
    end
    want_tx = 1; ready_k = 1;
    n = 0;
    while (busy() && n < 400) begin tick(); n++; end
    chk("cont_timeout", busy(), 0);
    check_streams("cont");
    run = 0; prev = 0; nruns = 0; badrun = 0;
    foreach (ev[i]) begin
      if (ev[i] == prev) run++;
      else begin
        if (prev != 0) begin nruns++; if (run != TXB) badrun++; end
        prev = ev[i]; run = 1;
      end
    end
    if (prev != 0) begin nruns++; if (run != TXB) badrun++; end
    chk("cont_first_rx", ev.size() != 0 ? ev[0] : 0, 1);
    chk("cont_runs", nruns, 20);
    chk("cont_runlen", badrun, 0);
    want_tx = 0;
    new_phase();

    // TX-only stream, 100 contiguous bytes
    for (int i = 0; i < 100; i++) add_tx(8'(i));
    want_tx = 1;
    c0 = cyc; n = 0;
    while (busy() && n < 300) begin tick(); n++; end
    chk("tx_timeout", busy(), 0);
    chk("tx_latency", first_wr, c0 + 1);
    chk("tx_contiguous", last_wr - first_wr + 1, 100);
    check_streams("tx_only");
    want_tx = 0;
    new_phase();

    // TX back-pressure after byte 10
    for (int i = 0; i < 100; i++) add_tx(8'(i));
    want_tx = 1; bp_done = 0; n = 0;
    while (busy() && n < 300) begin
      if (!bp_done && host_got.size() == 10) begin
        full_k = 1;
        repeat (3) tick();
        full_k = 0; bp_done = 1;
        chk("bp_hold", host_got.size(), 10);
      end else tick();
      n++;
    end
    chk("bp_timeout", busy(), 0);
    check_streams("bp");
    want_tx = 0;
    new_phase();

    // RX with user stall in cycles 3..6
    for (int i = 0; i < 8; i++) add_rx(8'(8'hA0 + i));
    c0 = cyc; n = 0;
    while (busy() && n < 60) begin
      ready_k = !(n >= 3 && n <= 6);
      tick(); n++;
    end
    ready_k = 1;
    chk("rx_timeout", busy(), 0);
    chk("rx_oe_latency", first_oe, c0 + 1);
    chk("rx_rd_latency", first_rd, c0 + 2);
    check_streams("rx_stall");
    new_phase();

    // flush with two queued TX bytes
    add_tx(8'h5A); add_tx(8'hA5);
    want_tx = 1; flush_k = 1;
    tick();
    flush_k = 0;
    repeat (12) tick();
    check_streams("flush");
`ifdef FT_SEND_IM_EN
    chk("flush_si_cycles", si_cnt, 1);
    chk("flush_after_tx", si_got, 2);
`else
    chk("flush_si_cycles", si_cnt, 0);
`endif
    want_tx = 0;
    new_phase();

    // randomized traffic against the scoreboards
    for (int i = 0; i < 2500; i++) begin
      while (txq.size() < 4) add_tx(8'($urandom));
      while (hostq.size() < 4) add_rx(8'($urandom));
      want_tx = $urandom_range(0, 3) != 0;
      full_k = $urandom_range(0, 5) == 0;
      block_k = $urandom_range(0, 3) == 0;
      ready_k = $urandom_range(0, 2) != 0;
      flush_k = $urandom_range(0, 30) == 0;
      tick();
    end
    want_tx = 1; full_k = 0; block_k = 0; ready_k = 1; flush_k = 0;
    n = 0;
    while (busy() && n < 500) begin tick(); n++; end
    chk("rand_timeout", busy(), 0);
    check_streams("rand");
    want_tx = 0;
    new_phase();

    // reset mid-burst with a full skid buffer
    for (int i = 0; i < 6; i++) add_rx(8'(8'h70 + i));
    ready_k = 0;
    repeat (8) tick();
    chk("pre_rst_skid", skid.size(), 2);
    chk_en = 0; rst = 1;
    tick();
    chk("mid_rst_rx_valid", rx_valid, 0);
    chk("mid_rst_out_en", out_en, 1);
    chk("mid_rst_read_n", read_n, 1);
    rst = 0; ready_k = 1;
    hostq.delete(); skid.delete();
    prev_oe = 1; gap_ok = 1; last_dir = 0; chk_en = 1;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ft245_bus_arbiter.md
# ft245_bus_arbiter

Sequencer and arbiter for the FT2232H 245-synchronous FIFO bus, clocked by the 60 MHz FTDI clock. It shares the single half-duplex 8-bit bus between an FPGA→host TX stream and a host→FPGA RX stream. It generates READ_N, WRITE_N, OUT_EN and SEND_IM with the required bus turnaround, and bounds burst lengths so neither direction starves. It sits directly between the FT2232H pins (TXE#, RXF#, RD#, WR#, OE#, SI/WUA#, ADBUS) and the user-side byte producers and consumers.

## Interface
- TX_BURST_MAX, 64: max bytes written per TX grant when RX is pending (≥1).
- RX_BURST_MAX, 64: max bytes read per RX grant when TX is pending (≥1).
- CLK_FTDI  in  1  60 MHz clock from the FT2232H; the block's only clock.
- RST  in  1  synchronous, active-high reset.
- TX_FULL  in  1  FT2232H TXE#; high means the host FIFO cannot accept.
- RX_EMPTY  in  1  FT2232H RXF#; high means no host byte is available.
- DATA_IN  in  8  ADBUS sampled from the pad.
- DATA_OUT  out  8  ADBUS drive value; equals TX_DATA.
- DATA_OE  out  1  pad tristate enable; 1 means the FPGA drives ADBUS.
- READ_N  out  1  FT2232H RD#.
- WRITE_N  out  1  FT2232H WR#.
- OUT_EN  out  1  FT2232H OE#.
- SEND_IM  out  1  FT2232H SI/WUA#.
- TX_VALID  in  1  a user TX byte is available.
- TX_DATA  in  8  user TX byte.
- TX_READY  out  1  TX byte consumed this cycle.
- RX_VALID  out  1  RX skid buffer head is valid.
- RX_DATA  out  8  RX skid buffer head byte.
- RX_READY  in  1  user pops the RX head.
- FLUSH  in  1  one-cycle request to push a short host packet (SI/WUA#).

## Operation
- States: IDLE, TX, RX_TURN, RX, RX_EXIT, SI.
- Pending conditions:
  - RX pending = !RX_EMPTY && rx_space, where rx_space = (cnt<2) || RX_READY.
  - TX pending = TX_VALID && !TX_FULL.
- IDLE arbitration, evaluated in this order:
  - FLUSH_PEND && !TX_VALID && !TX_FULL → SI.
  - Both RX and TX pending → grant the direction not served last. The last-served flag resets to TX, so RX wins the first tie.
  - Only one direction pending → grant it.
  - Grant TX → TX. Grant RX → RX_TURN.
- TX state:
  - DATA_OE=1.
  - WRITE_N = !(TX_VALID && !TX_FULL), combinational.
  - TX_READY = !WRITE_N.
  - A byte transfers on every edge where WRITE_N=0.
  - Leaves to IDLE when: TX_VALID=0, or TX_FULL=1, or (RX pending and byte count has reached TX_BURST_MAX).
- RX_TURN: OUT_EN=0, READ_N=1, DATA_OE=0. Lasts exactly one cycle, then → RX.
- RX state:
  - OUT_EN=0, DATA_OE=0.
  - READ_N = !(!RX_EMPTY && rx_space), combinational.
  - DATA_IN is pushed into the 2-entry RX skid buffer on every edge where READ_N=0 && RX_EMPTY=0.
  - Leaves to RX_EXIT when: RX_EMPTY=1, or (TX pending and byte count has reached RX_BURST_MAX), or (TX pending and cnt=2 without RX_READY).
- RX_EXIT: OUT_EN=1, READ_N=1, DATA_OE=0. Lasts one cycle (bus turnaround), then → IDLE.
- SI: SEND_IM=0 for exactly one cycle, FLUSH_PEND clears, then → IDLE.
- FLUSH sets FLUSH_PEND. Repeat FLUSH pulses while pending merge into one.
- Burst counter:
  - Width $clog2(max(TX_BURST_MAX,RX_BURST_MAX)+1).
  - Cleared on entering TX or RX; increments per transferred byte.
  - Saturates; never wraps.
- RX skid buffer:
  - RX_VALID = cnt>0; RX_DATA = head.
  - Simultaneous push and pop at cnt=2 is legal and keeps cnt=2.
  - An overflow is structurally impossible by the READ_N equation.
- Each state's outputs are as listed above; every output not listed in a state is inactive: READ_N, WRITE_N, OUT_EN and SEND_IM at 1; DATA_OE and TX_READY at 0.

## Timing
- Reset (synchronous; takes effect on the next CLK_FTDI edge with RST=1):
  - Outputs: READ_N=1, WRITE_N=1, OUT_EN=1, SEND_IM=1, DATA_OE=0, TX_READY=0, RX_VALID=0.
  - Internal: state IDLE, cnt=0, FLUSH_PEND=0, burst counter 0.
- Reset mid-burst: the bus is released on the next edge and buffered RX bytes are discarded.
- TX latency: first WRITE_N=0 occurs one cycle after TX pending is seen in IDLE. Sustained rate is 1 byte/cycle.
- RX latency: OUT_EN falls 1 cycle after the grant. First READ_N=0 is 1 cycle after OUT_EN falls. Sustained rate is 1 byte/cycle.
- Turnaround: OUT_EN=0 and DATA_OE=1 are never true in the same cycle. At least one cycle with both deasserted separates RX and TX.
- TX_FULL rising mid-burst: WRITE_N rises in the same cycle (combinational), so no byte is lost or duplicated.
- RX_EMPTY rising mid-burst: READ_N rises in the same cycle, and no push occurs.

## Configuration
- FT_SEND_IM_EN defined: FLUSH, FLUSH_PEND and the SI state behave as above.
- FT_SEND_IM_EN undefined: FLUSH is ignored, the SI state is absent, and SEND_IM is constant 1.

## Test plan
- Reset: hold RST=1 for 2 cycles with TX_VALID=1 and RX_EMPTY=0 → all FT outputs 1, DATA_OE=0, RX_VALID=0.
- TX-only stream: TX_VALID=1, 100 bytes 0x00..0x63, TX_FULL=0 → 100 contiguous WRITE_N=0 cycles, with DATA_OUT matching the input sequence.
- TX back-pressure: raise TX_FULL for 3 cycles after byte 10 → WRITE_N=1 in those cycles; all 100 bytes arrive exactly once and in order.
- RX with stall: RX_EMPTY=0, host sends 0xA0..0xA7, RX_READY low for cycles 3-6 → OUT_EN falls one cycle before READ_N; 8 bytes are popped in order with no loss.
- Contention: both directions pending continuously, TX_BURST_MAX=RX_BURST_MAX=4:
  - RX is served first.
  - Bursts alternate in groups of 4 bytes.
  - Each RX→TX switch has one RX_EXIT cycle with DATA_OE=0.
- Flush (FT_SEND_IM_EN defined): FLUSH pulse while 2 TX bytes are queued → both bytes are written, then SEND_IM=0 for exactly 1 cycle. With the macro undefined, SEND_IM stays 1.
